// File: rtl/fetch_unit.sv
// Program counter and fetch sequencer with a programmable branch-target LUT.
// Runs a start/done handshake and counts retired instructions.
module fetch_unit #(
  parameter int PC_W  = 10,
  parameter int IDX_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [PC_W-1:0]  StartAddr,
  input  logic             Halt,
  input  logic             Jump,
  input  logic             BranchEn,
  input  logic             BranchAccept,
  input  logic [IDX_W-1:0] TargetIdx,
  input  logic             LutWe,
  input  logic [IDX_W-1:0] LutWaddr,
  input  logic [PC_W-1:0]  LutWdata,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Running,
  output logic             Done,
  output logic [CNT_W-1:0] InstrCount
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [PC_W-1:0]  pc_nx;
  logic [PC_W-1:0]  target;
  logic [CNT_W-1:0] cnt_nx;
  logic             taken;

  logic [PC_W-1:0] lut [2**IDX_W];

  // Read before the write lands: a same-cycle write is seen next cycle.
  assign target = lut[TargetIdx];
  assign taken  = Jump || (BranchEn && BranchAccept);

  always_comb begin
    state_nx = state;
    pc_nx    = ProgCtr;
    cnt_nx   = InstrCount;
    if (Start) begin
      state_nx = S_RUN;
      pc_nx    = StartAddr;
      cnt_nx   = '0;
    end else if (state == S_RUN) begin
      if (InstrCount != {CNT_W{1'b1}})
        cnt_nx = InstrCount + CNT_W'(1);
      if (Halt)
        state_nx = S_HALT;
      else if (taken)
        pc_nx = target;
      else
        pc_nx = ProgCtr + PC_W'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= S_IDLE;
      ProgCtr    <= '0;
      InstrCount <= '0;
      Running    <= 1'b0;
      Done       <= 1'b0;
    end else begin
      state      <= state_nx;
      ProgCtr    <= pc_nx;
      InstrCount <= cnt_nx;
      Running    <= (state_nx == S_RUN);
      Done       <= (state_nx == S_HALT);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 2**IDX_W; i++)
        lut[i] <= '0;
    end else if (LutWe) begin
      lut[LutWaddr] <= LutWdata;
    end
  end

endmodule
